// File: rtl/bootstrap_readback.sv
// bootstrap_readback: after boot, reads back the SRAM images written by the
// bootstrapper (MLU slice, MLU lookahead, control microcode), accumulates a
// rotate-add 16-bit checksum and reports PASS/FAIL before the KPU is released.
// Optional feature: define BOOTSTRAP_READBACK_UART_EN to add an 8N1 UART_TX
// that echoes every sampled byte followed by the final checksum (low, high).
module bootstrap_readback #(
  parameter int unsigned SLICE_LEN     = 4096,
  parameter int unsigned LOOKAHEAD_LEN = 4096,
  parameter int unsigned CONTROL_LEN   = 4096,
  parameter int unsigned READ_WAIT     = 2,
  parameter logic [15:0] EXP_CHECKSUM  = 16'h0
`ifdef BOOTSTRAP_READBACK_UART_EN
  ,
  parameter int unsigned CLKS_PER_BIT  = 16
`endif
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic        N_BOOTED,
  input  logic        START,
  input  logic [7:0]  BOOTSTRAP_DATA,
  output logic [16:0] BOOTSTRAP_ADDR,
  output logic        MLU_SLICE_N_OE,
  output logic        MLU_LOOKAHEAD_N_OE,
  output logic        CONTROL_N_OE,
  output logic        BUSY,
  output logic        DONE,
  output logic        PASS,
  output logic [15:0] CHECKSUM
`ifdef BOOTSTRAP_READBACK_UART_EN
  ,
  output logic        UART_TX
`endif
);

  localparam int unsigned WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_SAMPLE,
    S_NEXT_REGION,
    S_FINISH
`ifdef BOOTSTRAP_READBACK_UART_EN
    ,
    S_CK_LO,
    S_CK_HI,
    S_DRAIN
`endif
  } state_t;

  state_t              state;
  logic [1:0]          region;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [2:0]          n_oe;
  logic                sample_go;

  // Byte count of each region; index 3 and above means "no more regions".
  function automatic logic [17:0] len_of(input logic [1:0] r);
    case (r)
      2'd0:    len_of = 18'(SLICE_LEN);
      2'd1:    len_of = 18'(LOOKAHEAD_LEN);
      2'd2:    len_of = 18'(CONTROL_LEN);
      default: len_of = '0;
    endcase
  endfunction

  assign MLU_SLICE_N_OE     = n_oe[0];
  assign MLU_LOOKAHEAD_N_OE = n_oe[1];
  assign CONTROL_N_OE       = n_oe[2];

`ifdef BOOTSTRAP_READBACK_UART_EN
  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             tx_start;
  logic [7:0]       tx_byte;
  logic             tx_busy;
  logic [8:0]       tx_shift;
  logic [3:0]       tx_bits;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_busy_any;

  // tx_start is a registered request, so the transmitter only sees it one
  // cycle later; fold it into busy so the FSM never issues two back to back.
  assign tx_busy_any = tx_busy | tx_start;
  assign sample_go   = ~tx_busy_any;

  // 8N1 transmitter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      UART_TX  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
    end else if (tx_start) begin
      UART_TX  <= 1'b0;
      tx_shift <= {1'b1, tx_byte};
      tx_bits  <= 4'd9;
      tx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt == '0) begin
        if (tx_bits == '0) begin
          tx_busy <= 1'b0;
        end else begin
          UART_TX  <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bits  <= tx_bits - 4'd1;
          tx_cnt   <= CNT_W'(CLKS_PER_BIT - 1);
        end
      end else begin
        tx_cnt <= tx_cnt - CNT_W'(1);
      end
    end
  end
`else
  assign sample_go = 1'b1;
`endif

  // Readback sequencer: walks regions 0..2, one byte per SETUP/WAIT/SAMPLE pass.
  always_ff @(posedge CLK) begin
    if (!N_RST) begin
      state          <= S_IDLE;
      region         <= '0;
      wait_cnt       <= '0;
      BOOTSTRAP_ADDR <= '0;
      n_oe           <= '1;
      BUSY           <= 1'b0;
      DONE           <= 1'b0;
      PASS           <= 1'b0;
      CHECKSUM       <= '0;
`ifdef BOOTSTRAP_READBACK_UART_EN
      tx_start       <= 1'b0;
      tx_byte        <= '0;
`endif
    end else begin
`ifdef BOOTSTRAP_READBACK_UART_EN
      tx_start <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (START && !N_BOOTED) begin
            CHECKSUM       <= '0;
            region         <= '0;
            BOOTSTRAP_ADDR <= '0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            BUSY           <= 1'b1;
            state          <= (len_of(2'd0) == '0) ? S_NEXT_REGION : S_SETUP;
          end
        end
        S_SETUP: begin
          n_oe     <= ~(3'b001 << region);
          wait_cnt <= WAIT_W'(READ_WAIT - 1);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == '0) state <= S_SAMPLE;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_SAMPLE: begin
          if (sample_go) begin
            CHECKSUM <= {CHECKSUM[14:0], CHECKSUM[15]} + {8'h00, BOOTSTRAP_DATA};
`ifdef BOOTSTRAP_READBACK_UART_EN
            tx_start <= 1'b1;
            tx_byte  <= BOOTSTRAP_DATA;
`endif
            if ({1'b0, BOOTSTRAP_ADDR} == len_of(region) - 18'd1) begin
              n_oe  <= '1;
              state <= S_NEXT_REGION;
            end else begin
              BOOTSTRAP_ADDR <= BOOTSTRAP_ADDR + 17'd1;
              state          <= S_SETUP;
            end
          end
        end
        // One cycle per region, including empty ones, keeps the run length fixed.
        S_NEXT_REGION: begin
          n_oe           <= '1;
          BOOTSTRAP_ADDR <= '0;
          region         <= region + 2'd1;
          if (region == 2'd2)
`ifdef BOOTSTRAP_READBACK_UART_EN
            state <= S_CK_LO;
`else
            state <= S_FINISH;
`endif
          else if (len_of(region + 2'd1) == '0)
            state <= S_NEXT_REGION;
          else
            state <= S_SETUP;
        end
`ifdef BOOTSTRAP_READBACK_UART_EN
        S_CK_LO: begin
          if (!tx_busy_any) begin
            tx_start <= 1'b1;
            tx_byte  <= CHECKSUM[7:0];
            state    <= S_CK_HI;
          end
        end
        S_CK_HI: begin
          if (!tx_busy_any) begin
            tx_start <= 1'b1;
            tx_byte  <= CHECKSUM[15:8];
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!tx_busy_any) state <= S_FINISH;
        end
`endif
        S_FINISH: begin
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          PASS  <= (CHECKSUM == EXP_CHECKSUM);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bootstrap_readback.sv
// Bench for bootstrap_readback: several configurations run side by side, each
// with its own SRAM model; expected reads and results are queued at START and
// popped as the DUTs produce them.
module tb_bootstrap_readback;

`ifdef BOOTSTRAP_READBACK_UART_EN
  localparam int NI = 4;
`else
  localparam int NI = 3;
`endif
  localparam int BOUND = 6000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       n_rst, n_booted, start;
  logic [7:0] data [NI];

  wire [16:0] addr [NI];
  wire [2:0]  noe  [NI];
  wire        busy [NI];
  wire        done [NI];
  wire        pass [NI];
  wire [15:0] csum [NI];
`ifdef BOOTSTRAP_READBACK_UART_EN
  wire        tx   [NI];
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [18:0] exp_rd  [NI][$];
  logic [16:0] exp_res [NI][$];
  int          multi_low [NI];
  int          r1_low    [NI];
  bit          prev_act  [NI];
  logic [1:0]  prev_r    [NI];
  logic [16:0] prev_a    [NI];

  bootstrap_readback #(.SLICE_LEN(4), .LOOKAHEAD_LEN(0), .CONTROL_LEN(2),
                       .READ_WAIT(1), .EXP_CHECKSUM(16'h00A8)) u_pass (
    .CLK(CLK), .N_RST(n_rst), .N_BOOTED(n_booted), .START(start),
    .BOOTSTRAP_DATA(data[0]), .BOOTSTRAP_ADDR(addr[0]),
    .MLU_SLICE_N_OE(noe[0][0]), .MLU_LOOKAHEAD_N_OE(noe[0][1]), .CONTROL_N_OE(noe[0][2]),
    .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]), .CHECKSUM(csum[0])
`ifdef BOOTSTRAP_READBACK_UART_EN
    , .UART_TX(tx[0])
`endif
  );

  bootstrap_readback #(.SLICE_LEN(4), .LOOKAHEAD_LEN(0), .CONTROL_LEN(2),
                       .READ_WAIT(1), .EXP_CHECKSUM(16'h00A9)) u_fail (
    .CLK(CLK), .N_RST(n_rst), .N_BOOTED(n_booted), .START(start),
    .BOOTSTRAP_DATA(data[1]), .BOOTSTRAP_ADDR(addr[1]),
    .MLU_SLICE_N_OE(noe[1][0]), .MLU_LOOKAHEAD_N_OE(noe[1][1]), .CONTROL_N_OE(noe[1][2]),
    .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]), .CHECKSUM(csum[1])
`ifdef BOOTSTRAP_READBACK_UART_EN
    , .UART_TX(tx[1])
`endif
  );

  bootstrap_readback #(.SLICE_LEN(1), .LOOKAHEAD_LEN(1), .CONTROL_LEN(1),
                       .READ_WAIT(2), .EXP_CHECKSUM(16'h06F9)) u_ones (
    .CLK(CLK), .N_RST(n_rst), .N_BOOTED(n_booted), .START(start),
    .BOOTSTRAP_DATA(data[2]), .BOOTSTRAP_ADDR(addr[2]),
    .MLU_SLICE_N_OE(noe[2][0]), .MLU_LOOKAHEAD_N_OE(noe[2][1]), .CONTROL_N_OE(noe[2][2]),
    .BUSY(busy[2]), .DONE(done[2]), .PASS(pass[2]), .CHECKSUM(csum[2])
`ifdef BOOTSTRAP_READBACK_UART_EN
    , .UART_TX(tx[2])
`endif
  );

`ifdef BOOTSTRAP_READBACK_UART_EN
  bootstrap_readback #(.SLICE_LEN(1), .LOOKAHEAD_LEN(0), .CONTROL_LEN(0),
                       .READ_WAIT(1), .EXP_CHECKSUM(16'h00A5), .CLKS_PER_BIT(4)) u_uart (
    .CLK(CLK), .N_RST(n_rst), .N_BOOTED(n_booted), .START(start),
    .BOOTSTRAP_DATA(data[3]), .BOOTSTRAP_ADDR(addr[3]),
    .MLU_SLICE_N_OE(noe[3][0]), .MLU_LOOKAHEAD_N_OE(noe[3][1]), .CONTROL_N_OE(noe[3][2]),
    .BUSY(busy[3]), .DONE(done[3]), .PASS(pass[3]), .CHECKSUM(csum[3]),
    .UART_TX(tx[3])
  );
`endif

  // Per-instance configuration as seen by the bench.
  function automatic int len_of(input int i, input int r);
    case (i)
      0, 1:    return (r == 0) ? 4 : ((r == 2) ? 2 : 0);
      2:       return 1;
      default: return (r == 0) ? 1 : 0;
    endcase
  endfunction

  function automatic int rw_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  function automatic logic [15:0] exp_of(input int i);
    case (i)
      0:       return 16'h00A8;
      1:       return 16'h00A9;
      2:       return 16'h06F9;
      default: return 16'h00A5;
    endcase
  endfunction

  function automatic logic [7:0] sram(input int i, input int r, input int a);
    if (i < 2) begin
      if (r == 0) return 8'(a + 1);
      return (a == 0) ? 8'h10 : 8'h20;
    end
    if (i == 2) return 8'hFF;
    return 8'hA5;
  endfunction

  function automatic logic [15:0] model_csum(input int i);
    logic [15:0] c;
    c = '0;
    for (int r = 0; r < 3; r++)
      for (int a = 0; a < len_of(i, r); a++)
        c = {c[14:0], c[15]} + {8'h00, sram(i, r, a)};
    return c;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  // SRAM models: data only for the single enabled region, junk otherwise.
  always_comb begin
    for (int i = 0; i < NI; i++) begin
      data[i] = 8'hEE;
      case (noe[i])
        3'b110:  data[i] = sram(i, 0, int'(addr[i]));
        3'b101:  data[i] = sram(i, 1, int'(addr[i]));
        3'b011:  data[i] = sram(i, 2, int'(addr[i]));
        default: data[i] = 8'hEE;
      endcase
    end
  end

  // Read-order monitor: each new (region, addr) under an active N_OE is one read.
  always @(negedge CLK) begin
    for (int i = 0; i < NI; i++) begin
      int          lows;
      logic [1:0]  r;
      logic [18:0] e;
      lows = $countones(~noe[i]);
      if (lows > 1) multi_low[i]++;
      if (noe[i][1] === 1'b0) r1_low[i]++;
      if (lows == 1) begin
        r = (noe[i][0] == 1'b0) ? 2'd0 : ((noe[i][1] == 1'b0) ? 2'd1 : 2'd2);
        if (mon_en && (!prev_act[i] || r != prev_r[i] || addr[i] != prev_a[i])) begin
          check("rd_expected", i, 32'(exp_rd[i].size() > 0), 32'd1);
          if (exp_rd[i].size() > 0) begin
            e = exp_rd[i].pop_front();
            check("rd_region", i, 32'(r), 32'(e[18:17]));
            check("rd_addr", i, 32'(addr[i]), 32'(e[16:0]));
          end
        end
        prev_act[i] = 1'b1;
        prev_r[i]   = r;
        prev_a[i]   = addr[i];
      end else begin
        prev_act[i] = 1'b0;
      end
    end
  end

`ifdef BOOTSTRAP_READBACK_UART_EN
  typedef struct packed {
    logic [7:0] b;
    logic       s0;
    logic       s1;
    logic       dn;
  } frame_t;
  frame_t     rx_q [$];
  logic [7:0] exp_tx [$];

  // 8N1 receiver for u_uart: 4 clocks/bit at 10 ns, sampled 2 ns past an edge.
  always begin : uart_rx
    logic [7:0] b;
    logic       s0, s1, dn;
    @(negedge tx[3]);
    #22 s0 = tx[3];
    for (int k = 0; k < 8; k++) begin
      #40;
      b[k] = tx[3];
    end
    #40;
    s1 = tx[3];
    dn = done[3];
    rx_q.push_back({b, s0, s1, dn});
  end
`endif

  task automatic do_run(input bit poke_busy);
    int          cyc;
    int          done_cyc [NI];
    bit          all_done;
    logic [15:0] c;
    logic [16:0] res;
    for (int i = 0; i < NI; i++) begin
      for (int r = 0; r < 3; r++)
        for (int a = 0; a < len_of(i, r); a++)
          exp_rd[i].push_back({2'(r), 17'(a)});
      c = model_csum(i);
      exp_res[i].push_back({(c == exp_of(i)), c});
    end
`ifdef BOOTSTRAP_READBACK_UART_EN
    for (int a = 0; a < len_of(3, 0); a++) exp_tx.push_back(sram(3, 0, a));
    c = model_csum(3);
    exp_tx.push_back(c[7:0]);
    exp_tx.push_back(c[15:8]);
`endif
    mon_en = 1'b1;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("busy_at_start", i, 32'(busy[i]), 32'd1);
      check("done_cleared", i, 32'(done[i]), 32'd0);
      done_cyc[i] = -1;
    end
    cyc      = 0;
    all_done = 1'b0;
    while (!all_done && cyc < BOUND) begin
      @(negedge CLK);
      cyc++;
      start    = poke_busy && (cyc == 5);
      all_done = 1'b1;
      for (int i = 0; i < NI; i++) begin
        if (done_cyc[i] < 0) begin
          if (done[i] === 1'b1) begin
            done_cyc[i] = cyc;
            if (exp_res[i].size() > 0) begin
              res = exp_res[i].pop_front();
              check("checksum", i, 32'(csum[i]), 32'(res[15:0]));
              check("pass", i, 32'(pass[i]), 32'(res[16]));
              check("busy_at_done", i, 32'(busy[i]), 32'd0);
            end
          end else begin
            all_done = 1'b0;
          end
        end
      end
    end
    start = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("done_seen", i, 32'(done_cyc[i] >= 0), 32'd1);
`ifndef BOOTSTRAP_READBACK_UART_EN
      check("latency", i, 32'(done_cyc[i]),
            32'((len_of(i, 0) + len_of(i, 1) + len_of(i, 2)) * (rw_of(i) + 2) + 4));
`endif
    end
    repeat (3) @(negedge CLK);
    for (int i = 0; i < NI; i++) begin
      check("done_hold", i, 32'(done[i]), 32'd1);
      check("busy_idle", i, 32'(busy[i]), 32'd0);
      check("reads_left", i, 32'(exp_rd[i].size()), 32'd0);
      exp_rd[i].delete();
      exp_res[i].delete();
    end
`ifdef BOOTSTRAP_READBACK_UART_EN
    check("uart_frames", 3, 32'(rx_q.size()), 32'(exp_tx.size()));
    for (int k = 0; k < exp_tx.size() && k < rx_q.size(); k++) begin
      check("uart_byte", k, 32'(rx_q[k].b), 32'(exp_tx[k]));
      check("uart_start", k, 32'(rx_q[k].s0), 32'd0);
      check("uart_stop", k, 32'(rx_q[k].s1), 32'd1);
      check("uart_done_early", k, 32'(rx_q[k].dn), 32'd0);
    end
    rx_q.delete();
    exp_tx.delete();
`endif
  endtask

  initial begin
    n_rst    = 1'b0;
    n_booted = 1'b1;
    start    = 1'b0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < NI; i++) begin
      check("rst_busy", i, 32'(busy[i]), 32'd0);
      check("rst_done", i, 32'(done[i]), 32'd0);
      check("rst_pass", i, 32'(pass[i]), 32'd0);
      check("rst_csum", i, 32'(csum[i]), 32'd0);
      check("rst_addr", i, 32'(addr[i]), 32'd0);
      check("rst_noe", i, 32'(noe[i]), 32'h7);
`ifdef BOOTSTRAP_READBACK_UART_EN
      check("rst_tx", i, 32'(tx[i]), 32'd1);
`endif
    end
    n_rst = 1'b1;
    @(negedge CLK);

    // START while still booting must be ignored.
    start = 1'b1;
    @(negedge CLK) start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < NI; i++) begin
        check("nbooted_busy", i, 32'(busy[i]), 32'd0);
        check("nbooted_noe", i, 32'(noe[i]), 32'h7);
      end
      @(negedge CLK);
    end

    n_booted = 1'b0;
    do_run(1'b1);
    check("csum_rotate_add", 0, 32'(csum[0]), 32'h00A8);
    check("csum_ff_chain", 2, 32'(csum[2]), 32'h06F9);
    do_run(1'b0);

    for (int i = 0; i < NI; i++) check("one_noe_low", i, 32'(multi_low[i]), 32'd0);
    for (int i = 0; i < 2; i++) check("lookahead_unused", i, 32'(r1_low[i]), 32'd0);

    // Reset 20 cycles into a run aborts without a partial DONE.
    mon_en = 1'b0;
    @(negedge CLK) start = 1'b1;
    @(negedge CLK) start = 1'b0;
    repeat (20) @(negedge CLK);
    n_rst = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < NI; i++) begin
      check("abort_busy", i, 32'(busy[i]), 32'd0);
      check("abort_done", i, 32'(done[i]), 32'd0);
      check("abort_noe", i, 32'(noe[i]), 32'h7);
      check("abort_csum", i, 32'(csum[i]), 32'd0);
`ifdef BOOTSTRAP_READBACK_UART_EN
      check("abort_tx", i, 32'(tx[i]), 32'd1);
`endif
    end
    n_rst = 1'b1;
    repeat (2) @(negedge CLK);
    check("abort_stays_idle", 0, 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
